// File: rtl/key_scan_if.sv
// ----------------------------------------------------------------------------
// key_scan_if
//   Key-event stream between the key scanner and its consumer.
//
//   Signals
//     evt_valid  head event present (queue non-empty)
//     evt_ready  consumer takes the head event when evt_valid && evt_ready
//     evt_data   {release flag, key index[3:0]} of the head event
//     evt_count  number of queued events
//
//   Modports
//     master  producer side (key_scan)
//     slave   consumer side
// ----------------------------------------------------------------------------
interface key_scan_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             evt_valid;
    logic             evt_ready;
    logic [4:0]       evt_data;
    logic [CNT_W-1:0] evt_count;

    modport master (
        output evt_valid,
        output evt_data,
        output evt_count,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        input  evt_count,
        output evt_ready
    );
endinterface

// File: rtl/key_scan.sv
// ----------------------------------------------------------------------------
// key_scan
//   Debounced 16-bit key/switch scanner. Raw keys are synchronized through
//   two flops, then sampled on a shared slow tick. A key's debounced level
//   flips only after DEB_TICKS consecutive tick samples differ from it.
//   Each level flip raises a pending flag. An arbiter turns one pending flag
//   per cycle into a key-code event in a small FIFO. The consumer drains
//   the FIFO with a valid/ready handshake.
//
//   Optional feature macro: KEY_RELEASE_EVT_EN
//     defined   : 1->0 flips also queue events (evt_data[4] = 1)
//     undefined : only press events are queued, evt_data[4] is always 0
//
//   Parameters
//     TICK_DIV    clk cycles per debounce sample tick (>= 2)
//     DEB_TICKS   consecutive differing samples needed to flip a level (>= 1)
//     FIFO_DEPTH  event queue depth, power of 2, >= 2
//
//   Ports
//     i_clk        system clock
//     i_rst_n      asynchronous active-low reset
//     i_key_in     raw key inputs, active-high, asynchronous to i_clk
//     o_key_level  debounced key state
//     evt          event stream (key_scan_if.master)
// ----------------------------------------------------------------------------
module key_scan #(
    parameter int TICK_DIV   = 50000,
    parameter int DEB_TICKS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_key_in,
    output logic [15:0] o_key_level,
    key_scan_if.master  evt
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W  = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]       r_sync1;
    logic [15:0]       r_sync2;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [DEB_W-1:0]  r_deb_cnt [16];
    logic [15:0]       r_level;
    logic [15:0]       r_level_d;     // level one cycle ago, for edge detect
    logic [15:0]       r_press_pend;
`ifdef KEY_RELEASE_EVT_EN
    logic [15:0]       r_rel_pend;
`endif
    logic [4:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic        w_tick;
    logic [15:0] w_press_set;
    logic [15:0] w_press_clr;
    logic        w_press_any;
    logic [3:0]  w_press_idx;
`ifdef KEY_RELEASE_EVT_EN
    logic [15:0] w_rel_set;
    logic [15:0] w_rel_clr;
    logic        w_rel_any;
    logic [3:0]  w_rel_idx;
`endif
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [4:0]  w_push_data;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Flips are detected from the registered level, so a flag raised here
    // becomes visible one cycle after the level flip. The arbiter only
    // reads the registered flags, so a flag is never served in the same
    // cycle it is raised.
    assign w_press_set = r_level & ~r_level_d;
`ifdef KEY_RELEASE_EVT_EN
    assign w_rel_set   = ~r_level & r_level_d;
`endif

    // ------------------------------------------------------------------
    // Synchronizer and tick generator
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync1    <= i_key_in;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce. Any agreeing sample restarts the count, so only an
    // unbroken run of DEB_TICKS differing samples flips the level.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_deb_cnt[i] <= '0;
            end
            r_level   <= '0;
            r_level_d <= '0;
        end else begin
            r_level_d <= r_level;
            if (w_tick) begin
                for (int i = 0; i < 16; i++) begin
                    if (r_sync2[i] == r_level[i]) begin
                        r_deb_cnt[i] <= '0;
                    end else if (r_deb_cnt[i] == DEB_LAST) begin
                        r_level[i]   <= ~r_level[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Enqueue arbiter: lowest-index press first, then lowest-index release.
    // The downward loop leaves the lowest set index as the final write.
    // ------------------------------------------------------------------
    always_comb begin
        w_press_any = |r_press_pend;
        w_press_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (r_press_pend[i]) begin
                w_press_idx = 4'(i);
            end
        end
`ifdef KEY_RELEASE_EVT_EN
        w_rel_any = |r_rel_pend;
        w_rel_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (r_rel_pend[i]) begin
                w_rel_idx = 4'(i);
            end
        end
`endif

        // Full is judged on the registered count only; a pop in the same
        // cycle frees space for the next cycle, never this one.
        w_full = (r_count == FIFO_FULL);

`ifdef KEY_RELEASE_EVT_EN
        w_push      = !w_full && (w_press_any || w_rel_any);
        w_push_data = w_press_any ? {1'b0, w_press_idx} : {1'b1, w_rel_idx};
        w_press_clr = (w_push && w_press_any) ? (16'd1 << w_press_idx) : 16'd0;
        w_rel_clr   = (w_push && !w_press_any) ? (16'd1 << w_rel_idx) : 16'd0;
`else
        w_push      = !w_full && w_press_any;
        w_push_data = {1'b0, w_press_idx};
        w_press_clr = w_push ? (16'd1 << w_press_idx) : 16'd0;
`endif

        w_pop = (r_count != '0) && evt.evt_ready;
    end

    // ------------------------------------------------------------------
    // Pending flags. A new flip of a bit whose flag is still set merges
    // into it; the set term wins over a same-cycle clear so it is not lost.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_press_pend <= '0;
`ifdef KEY_RELEASE_EVT_EN
            r_rel_pend   <= '0;
`endif
        end else begin
            r_press_pend <= (r_press_pend & ~w_press_clr) | w_press_set;
`ifdef KEY_RELEASE_EVT_EN
            r_rel_pend   <= (r_rel_pend & ~w_rel_clr) | w_rel_set;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO. Pointers wrap naturally because the depth is a power of
    // two. Storage is cleared on reset so the head data reads 0 after it.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all taken directly from registers
    // ------------------------------------------------------------------
    assign o_key_level   = r_level;
    assign evt.evt_valid = (r_count != '0);
    assign evt.evt_data  = r_mem[r_rd_ptr];
    assign evt.evt_count = r_count;

endmodule

// File: tb/tb_key_scan.sv
module tb_key_scan;

    localparam int TICK_DIV   = 4;
    localparam int DEB_TICKS  = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] key_in = '0;
    logic [15:0] key_level;

    int n_tests = 0;
    int n_fail  = 0;

    key_scan_if #(.FIFO_DEPTH(FIFO_DEPTH)) evt_if ();

    key_scan #(
        .TICK_DIV   (TICK_DIV),
        .DEB_TICKS  (DEB_TICKS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_key_in    (key_in),
        .o_key_level (key_level),
        .evt         (evt_if.master)
    );

    always #5 clk = ~clk;

    // Reset with all keys released; returns right after release at a negedge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        key_in = '0;
        evt_if.evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        key_in = 16'hFFFF;
        evt_if.evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (key_level !== 16'h0000) begin
            n_fail++; $display("FAIL reset_level got=%h exp=0000", key_level);
        end
        n_tests++;
        if (evt_if.evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got=%b exp=0", evt_if.evt_valid);
        end
        n_tests++;
        if (evt_if.evt_count !== CNT_W'(0)) begin
            n_fail++; $display("FAIL reset_count got=%0d exp=0", evt_if.evt_count);
        end
        n_tests++;
        if (evt_if.evt_data !== 5'h00) begin
            n_fail++; $display("FAIL reset_data got=%h exp=00", evt_if.evt_data);
        end
        // 2 sync edges, first tick on the 4th edge, flip on the 3rd tick (edge 12)
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        n_tests++;
        if (key_level !== 16'hFFFF) begin
            n_fail++; $display("FAIL reset_release_level got=%h exp=ffff", key_level);
        end
        // 16 presses with no consumer: queue fills to 4 holding key 0 at the head
        repeat (10) @(negedge clk);
        n_tests++;
        if (evt_if.evt_count !== CNT_W'(4)) begin
            n_fail++; $display("FAIL reset_fill_count got=%0d exp=4", evt_if.evt_count);
        end
        n_tests++;
        if (evt_if.evt_data !== 5'h00) begin
            n_fail++; $display("FAIL reset_fill_data got=%h exp=00", evt_if.evt_data);
        end
        // Asynchronous assertion mid-cycle clears everything without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (evt_if.evt_count !== CNT_W'(0) || evt_if.evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_fifo got count=%0d valid=%b exp=0/0",
                               evt_if.evt_count, evt_if.evt_valid);
        end
        n_tests++;
        if (key_level !== 16'h0000) begin
            n_fail++; $display("FAIL async_reset_level got=%h exp=0000", key_level);
        end
    endtask

    task automatic test_bounce();
        logic saw_bad;
        saw_bad = 1'b0;
        do_reset();
        evt_if.evt_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            key_in[3] = ~key_in[3];
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (evt_if.evt_valid || key_level[3]) saw_bad = 1'b1;
            end
        end
        key_in[3] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (evt_if.evt_valid || key_level[3]) saw_bad = 1'b1;
        end
        n_tests++;
        if (saw_bad !== 1'b0) begin
            n_fail++; $display("FAIL bounce_activity got=%b exp=0", saw_bad);
        end
        n_tests++;
        if (key_level !== 16'h0000 || evt_if.evt_count !== CNT_W'(0)) begin
            n_fail++; $display("FAIL bounce_final got level=%h count=%0d exp=0000/0",
                               key_level, evt_if.evt_count);
        end
    endtask

    task automatic test_single_press();
        int cyc;
        cyc = 0;
        do_reset();
        evt_if.evt_ready = 1'b0;
        key_in[5] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (key_level[5]) begin
                cyc = i;
                break;
            end
        end
        n_tests++;
        if (cyc !== 12) begin
            n_fail++; $display("FAIL single_latency got=%0d exp=12", cyc);
        end
        n_tests++;
        if (key_level !== 16'h0020) begin
            n_fail++; $display("FAIL single_level got=%h exp=0020", key_level);
        end
        @(negedge clk);
        n_tests++;
        if (evt_if.evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_valid_t1 got=%b exp=0", evt_if.evt_valid);
        end
        @(negedge clk);
        n_tests++;
        if (evt_if.evt_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_valid_t2 got=%b exp=1", evt_if.evt_valid);
        end
        n_tests++;
        if (evt_if.evt_data !== 5'h05 || evt_if.evt_count !== CNT_W'(1)) begin
            n_fail++; $display("FAIL single_event got data=%h count=%0d exp=05/1",
                               evt_if.evt_data, evt_if.evt_count);
        end
        // Held without ready: the head must not change
        repeat (3) @(negedge clk);
        n_tests++;
        if (evt_if.evt_data !== 5'h05 || evt_if.evt_count !== CNT_W'(1)) begin
            n_fail++; $display("FAIL single_hold got data=%h count=%0d exp=05/1",
                               evt_if.evt_data, evt_if.evt_count);
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp_q [4];
        int cyc;
        exp_q[0] = 5'd0; exp_q[1] = 5'd5; exp_q[2] = 5'd10; exp_q[3] = 5'd15;
        cyc = 0;
        do_reset();
        evt_if.evt_ready = 1'b1;
        key_in = 16'h8421;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (evt_if.evt_valid) begin
                cyc = i;
                break;
            end
        end
        // flip at 12, flag at 13, first valid at 14
        n_tests++;
        if (cyc !== 14) begin
            n_fail++; $display("FAIL simul_latency got=%0d exp=14", cyc);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== exp_q[k]) begin
                n_fail++; $display("FAIL simul_evt%0d got valid=%b data=%h exp=1/%h",
                                   k, evt_if.evt_valid, evt_if.evt_data, exp_q[k]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (evt_if.evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL simul_drained got=%b exp=0", evt_if.evt_valid);
        end
    endtask

    task automatic test_backpressure();
        int got;
        got = 0;
        do_reset();
        evt_if.evt_ready = 1'b0;
        key_in = 16'h003F;
        repeat (24) @(negedge clk);
        n_tests++;
        if (evt_if.evt_count !== CNT_W'(4)) begin
            n_fail++; $display("FAIL bp_count got=%0d exp=4", evt_if.evt_count);
        end
        n_tests++;
        if (evt_if.evt_data !== 5'h00) begin
            n_fail++; $display("FAIL bp_head got=%h exp=00", evt_if.evt_data);
        end
        evt_if.evt_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (evt_if.evt_valid) begin
                n_tests++;
                if (evt_if.evt_data !== 5'(got)) begin
                    n_fail++; $display("FAIL bp_order got=%h exp=%h", evt_if.evt_data, 5'(got));
                end
                got++;
            end
            @(negedge clk);
        end
        n_tests++;
        if (got !== 6) begin
            n_fail++; $display("FAIL bp_delivered got=%0d exp=6", got);
        end
        n_tests++;
        if (evt_if.evt_count !== CNT_W'(0)) begin
            n_fail++; $display("FAIL bp_empty got=%0d exp=0", evt_if.evt_count);
        end
    endtask

    task automatic test_release();
        logic       found;
        logic [4:0] data;
        found = 1'b0;
        data = '0;
        do_reset();
        evt_if.evt_ready = 1'b1;
        key_in[2] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (evt_if.evt_valid) begin
                found = 1'b1;
                data = evt_if.evt_data;
                break;
            end
        end
        n_tests++;
        if (found !== 1'b1 || data !== 5'h02) begin
            n_fail++; $display("FAIL release_press got found=%b data=%h exp=1/02", found, data);
        end
        @(negedge clk);
        key_in[2] = 1'b0;
        found = 1'b0;
        data = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (evt_if.evt_valid) begin
                found = 1'b1;
                data = evt_if.evt_data;
                break;
            end
        end
        n_tests++;
        if (key_level !== 16'h0000) begin
            n_fail++; $display("FAIL release_level got=%h exp=0000", key_level);
        end
`ifdef KEY_RELEASE_EVT_EN
        n_tests++;
        if (found !== 1'b1 || data !== 5'h12) begin
            n_fail++; $display("FAIL release_event got found=%b data=%h exp=1/12", found, data);
        end
`else
        n_tests++;
        if (found !== 1'b0) begin
            n_fail++; $display("FAIL release_no_event got found=%b data=%h exp=0", found, data);
        end
`endif
    endtask

    initial begin
        evt_if.evt_ready = 1'b0;
        test_reset();
        test_bounce();
        test_single_press();
        test_simultaneous();
        test_backpressure();
        test_release();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
